// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N_CH-input, W-bit stream multiplexer with valid/ready handshakes and a
//   single registered output stage. The source is picked either by an explicit
//   select (mode=0) or by round-robin among valid channels (mode=1).
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : channel i at [i*W +: W]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, at most one bit set)
//   mode       : 0 = explicit select, 1 = round-robin
//   sel        : channel select for mode 0
//   out_data   : registered output word
//   out_ch     : registered id of the channel that supplied out_data
//   out_valid  : registered output valid
//   out_ready  : consumer ready
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [SEL_W-1:0] SEL_ONE = 1;

    logic [W-1:0]     data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic [SEL_W-1:0] cand;
    logic             cand_ok;
    logic             cand_valid;
    logic [W-1:0]     cand_data;
    logic             xfer;
    logic [SEL_W-1:0] cand_inc;

    assign load_en = !valid_q || out_ready;

    // Candidate selection. In round-robin mode the search starts at ptr and
    // wraps; the first valid channel found wins.
    always_comb begin
        int idx;
        cand    = '0;
        cand_ok = 1'b0;
        idx     = 0;
        if (!mode) begin
            cand    = sel;
            cand_ok = (int'(sel) < N_CH);
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (!cand_ok && i == idx && in_valid[i]) begin
                        cand_ok = 1'b1;
                        cand    = idx[SEL_W-1:0];
                    end
                end
            end
        end
    end

    // Constant-index mux of the candidate's data and valid (cand may be out
    // of range in mode 0, which must simply select nothing).
    always_comb begin
        cand_data  = '0;
        cand_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(cand) == i) begin
                cand_data  = in_data[i*W +: W];
                cand_valid = in_valid[i];
            end
        end
    end

    // in_ready is held low during reset; the reset value of valid_q alone
    // would otherwise make load_en true.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rst_n && cand_ok && load_en && int'(cand) == i) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    assign xfer     = rst_n && cand_ok && load_en && cand_valid;
    assign cand_inc = (int'(cand) == N_CH - 1) ? '0 : cand + SEL_ONE;

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = cand_data;
            ch_d    = cand;
            valid_d = 1'b1;
            if (mode) begin
                ptr_d = cand_inc;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    // second instance with a non-power-of-two channel count
    logic [11:0] d3_data;
    logic [2:0]  d3_valid;
    logic [2:0]  d3_ready;
    logic        d3_mode;
    logic [1:0]  d3_sel;
    logic [3:0]  d3_out_data;
    logic [1:0]  d3_out_ch;
    logic        d3_out_valid;
    logic        d3_out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic       m_valid;
    logic [3:0] m_data;
    int         m_ch;
    int         m_ptr;

    stream_mux_rr #(.N_CH(4), .W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(3), .W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(d3_valid),
        .in_ready(d3_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data),
        .out_ch(d3_out_ch), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel should be offered a slot, and the ready vector that follows.
    task automatic model_eval(output logic [3:0] er, output int c);
        logic le;
        logic found;
        er = '0;
        c  = -1;
        if (rst_n) begin
            le = !m_valid || out_ready;
            if (!mode) begin
                if (int'(sel) < N) c = int'(sel);
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && in_valid[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        c = (m_ptr + k) % N;
                    end
                end
            end
            if (c >= 0 && le) er[c] = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    // One clock: check combinational ready before the edge, advance the
    // model at the edge, check registered outputs just after.
    task automatic tick();
        logic [3:0] er;
        int         c;
        logic       x;
        #1;
        model_eval(er, c);
        chk("in_ready", {28'd0, in_ready}, {28'd0, er});
        x = 1'b0;
        if (c >= 0) x = er[c] && in_valid[c];
        @(posedge clk);
        if (x) begin
            m_valid = 1'b1;
            m_data  = in_data[c*4 +: 4];
            m_ch    = c;
            if (mode) m_ptr = (c + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_data", {28'd0, out_data}, {28'd0, m_data});
        chk("out_ch", {30'd0, out_ch}, m_ch);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [15:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic [3:0]  e_data;
        logic [1:0]  e_ch;
        logic        e_valid;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b0, 2'd0, 4'hf, 16'hdcba, 1'b1, 4'b0001, 4'ha, 2'd0, 1'b1};
        tbl[1] = '{1'b0, 2'd1, 4'hf, 16'hdcba, 1'b1, 4'b0010, 4'hb, 2'd1, 1'b1};
        tbl[2] = '{1'b0, 2'd2, 4'hf, 16'hdcba, 1'b1, 4'b0100, 4'hc, 2'd2, 1'b1};
        tbl[3] = '{1'b0, 2'd3, 4'hf, 16'hdcba, 1'b1, 4'b1000, 4'hd, 2'd3, 1'b1};
        // selected channel not valid: ready still offered, output drains
        tbl[4] = '{1'b0, 2'd2, 4'hb, 16'hdcba, 1'b1, 4'b0100, 4'hd, 2'd3, 1'b0};
        // empty register loads even with consumer not ready
        tbl[5] = '{1'b0, 2'd1, 4'hf, 16'hdcba, 1'b0, 4'b0010, 4'hb, 2'd1, 1'b1};
        // stall: nothing offered, word held
        tbl[6] = '{1'b0, 2'd0, 4'hf, 16'hdcba, 1'b0, 4'b0000, 4'hb, 2'd1, 1'b1};

        in_data = 16'hdcba; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
        d3_data = 12'hcba; d3_valid = '0; d3_mode = 1'b0; d3_sel = '0; d3_out_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
        do_reset();

        // table-driven mode-0 vectors
        for (int i = 0; i < 7; i++) begin
            mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].vld;
            in_data = tbl[i].dat; out_ready = tbl[i].ordy;
            #1;
            chk("tbl_ready", {28'd0, in_ready}, {28'd0, tbl[i].e_rdy});
            tick();
            chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            chk("tbl_data", {28'd0, out_data}, {28'd0, tbl[i].e_data});
            chk("tbl_ch", {30'd0, out_ch}, {30'd0, tbl[i].e_ch});
        end

        // round-robin, all valid: 0,1,2,3,0,1,2,3
        do_reset();
        mode = 1'b1; in_valid = 4'hf; out_ready = 1'b1; in_data = 16'hdcba;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_all_ch", {30'd0, out_ch}, i % 4);
            chk("rr_all_valid", {31'd0, out_valid}, 32'd1);
        end

        // round-robin, channels 1 and 3 only
        do_reset();
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_13_noready02", {28'd0, in_ready & 4'b0101}, 32'd0);
            tick();
            chk("rr_13_ch", {30'd0, out_ch}, (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // back-pressure
        do_reset();
        mode = 1'b0; sel = 2'd0; in_valid = 4'hf; in_data = 16'hdcb7; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_data = 16'hdcb9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {28'd0, in_ready}, 32'd0);
            tick();
            chk("bp_data", {28'd0, out_data}, 32'h7);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, in_ready}, 32'b0001);
        tick();
        chk("bp_next_data", {28'd0, out_data}, 32'h9);

        // reset mid-stream
        in_data = 16'hdcb5;
        tick();
        chk("mid_loaded", {28'd0, out_data}, 32'h5);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {28'd0, out_data}, 32'd0);
        chk("mid_rst_ch", {30'd0, out_ch}, 32'd0);
        chk("mid_rst_ready", {28'd0, in_ready}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 4'b1100; in_data = 16'hdcba;
        tick();
        chk("mid_first_grant", {30'd0, out_ch}, 32'd2);
        chk("mid_first_data", {28'd0, out_data}, 32'hc);

        // N_CH=3, out-of-range select
        d3_valid = 3'b111; d3_sel = 2'd1; d3_out_ready = 1'b1;
        tick();
        chk("n3_load_ch", {30'd0, d3_out_ch}, 32'd1);
        chk("n3_load_valid", {31'd0, d3_out_valid}, 32'd1);
        d3_sel = 2'd3; d3_out_ready = 1'b0;
        #1;
        chk("n3_stall_ready", {29'd0, d3_ready}, 32'd0);
        tick();
        chk("n3_held_valid", {31'd0, d3_out_valid}, 32'd1);
        d3_out_ready = 1'b1;
        #1;
        chk("n3_oor_ready", {29'd0, d3_ready}, 32'd0);
        tick();
        chk("n3_drained_valid", {31'd0, d3_out_valid}, 32'd0);
        chk("n3_held_ch", {30'd0, d3_out_ch}, 32'd1);
        tick();
        chk("n3_oor_stays", {31'd0, d3_out_valid}, 32'd0);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with a valid/ready handshake on every input and on the single output. It has one registered output stage. The block selects a source either from an explicit `sel` input (mode 0) or by round-robin arbitration among valid channels (mode 1). It is the next-generation replacement for the fixed 4:1 combinational `case` multiplexers, intended for merging several producer streams into one consumer.

## Interface
- `N_CH`, default 4: number of input channels; legal range 2..16.
- `W`, default 4: data width per channel; legal range ≥1.
- `SEL_W`, default `$clog2(N_CH)`: derived width of select/channel-id fields; not to be overridden.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, N_CH*W: channel i occupies bits [i*W +: W].
- `in_valid`, in, N_CH: per-channel valid.
- `in_ready`, out, N_CH: per-channel ready (combinational).
- `mode`, in, 1: 0 = explicit select, 1 = round-robin.
- `sel`, in, SEL_W: channel select, used in mode 0 only.
- `out_data`, out, W: registered output data.
- `out_ch`, out, SEL_W: registered id of the channel that supplied `out_data`.
- `out_valid`, out, 1: registered output valid.
- `out_ready`, in, 1: consumer ready.

## Operation
- Registered state: `out_data`, `out_ch`, `out_valid`, and the round-robin pointer `ptr` (SEL_W bits).
- `load_en = !out_valid || out_ready`. The output register accepts a new word only when `load_en` is 1.
- Mode 0:
  - The candidate channel `c` is `sel`.
  - `in_ready[sel] = load_en`; all other `in_ready` bits are 0.
  - `in_ready` does not depend on `in_valid`.
  - If `sel >= N_CH`, all `in_ready` bits are 0 and no transfer occurs.
- Mode 1:
  - The candidate `c` is the first channel with `in_valid` set, searching `ptr, ptr+1, …, N_CH-1, 0, …, ptr-1`.
  - If no channel is valid, all `in_ready` bits are 0.
  - Otherwise `in_ready[c] = load_en` and all other bits are 0.
- An input transfer happens on channel c when `in_valid[c] && in_ready[c]`. On that clock edge:
  - `out_data <= in_data[c]`.
  - `out_ch <= c`.
  - `out_valid <= 1`.
  - In mode 1 only, `ptr <= (c+1) mod N_CH`, wrapping from N_CH-1 to 0.
- If there is no input transfer and `out_ready` is 1, then `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- Stall (`out_valid && !out_ready`):
  - `out_data`, `out_ch` and `out_valid` hold stable.
  - All `in_ready` bits are 0.
- `ptr` is not modified in mode 0.
- A change of `mode` or `sel` affects only the next choice of candidate. A word already held in the output register is unaffected.
- No data is ever duplicated or dropped, except as described under reset.

## Timing
- Reset (`rst_n` low, asynchronous): `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`.
  - Outputs take these values immediately, with no clock needed.
  - `in_ready` is all 0 while `rst_n` is low.
- Reset asserted mid-stream: the held output word is discarded. After release, the first transfer can occur on the first rising edge that sees `rst_n` high.
- Latency: a word transferred at edge k is presented on `out_data`/`out_valid` after edge k, i.e. 1 cycle.
- Throughput: one word per cycle while `out_ready` stays 1, because `in_ready` passes `out_ready` through combinationally.
- Simultaneous events:
  - When the consumer pops the output and an input transfer happens in the same cycle, the register reloads and `out_valid` stays 1.
  - When several channels are valid in mode 1, exactly one `in_ready` bit is asserted.

## Test plan
- Mode 0, `out_ready=1`, `in_data={d,c,b,a}` (channel 3..0) with values a=4'ha, b=4'hb, c=4'hc, d=4'hd, all valid, `sel` stepping 0,1,2,3 → the cycle after each step `out_data` = a,b,c,d and `out_ch` = 0,1,2,3; `in_ready` is one-hot on `sel`.
- Mode 1, all 4 channels always valid, `out_ready=1` for 8 cycles → `out_ch` sequence 0,1,2,3,0,1,2,3 (wrap-around); one word per cycle.
- Mode 1, only channels 1 and 3 valid, `ptr=0` after reset → `out_ch` sequence 1,3,1,3; channels 0 and 2 never get `in_ready`.
- Back-pressure: one word loaded with value 4'h7, then `out_ready=0` for 3 cycles → `out_data=7` and `out_valid=1` stay stable, `in_ready=0`; raising `out_ready` accepts the next word within the same cycle.
- Reset mid-stream: `out_valid=1`, `out_data=4'h5`, then `rst_n=0` between clock edges → `out_valid`, `out_data` and `out_ch` go to 0 immediately; after release in mode 1, the first grant goes to the lowest valid channel, since `ptr=0`.
- Mode 0 with `N_CH=3` and `sel=3` (out of range), all channels valid → `in_ready=0` and `out_valid` falls to 0 after any pending word is consumed.
